// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
package imem_loader_pkg;

    localparam int ADDR_W  = 12;
    localparam int INSTR_W = 19;
    localparam int BYTE_W  = 8;

    // Upper bits of the first byte of each word must be zero.
    localparam logic [4:0] FRAME_HI = 5'b0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_B0,
        S_B1,
        S_B2,
        S_WRITE
    } state_t;

endpackage

// File: rtl/loader_word_asm.sv
// Assembles a 19-bit instruction word from three MSB-first stream bytes and
// flags a malformed first byte.
module loader_word_asm
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_load,
    input  logic [1:0]  i_idx,
    input  logic [7:0]  i_byte,
    output logic [18:0] o_word_next,
    output logic        o_frame_err
);

    logic [18:0] r_word;
    logic [18:0] w_next;

    // o_word_next already contains the byte being loaded, so the caller can
    // capture the complete word on the same edge the last byte arrives.
    always_comb begin
        w_next = r_word;
        if (i_load) begin
            case (i_idx)
                2'd0:    w_next[18:16] = i_byte[2:0];
                2'd1:    w_next[15:8]  = i_byte;
                default: w_next[7:0]   = i_byte;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_word <= '0;
        end else if (i_clr) begin
            r_word <= '0;
        end else if (i_load) begin
            r_word <= w_next;
        end
    end

    assign o_word_next = w_next;
    assign o_frame_err = i_load && (i_idx == 2'd0) && (i_byte[7:3] != FRAME_HI);

endmodule

// File: rtl/imem_loader.sv
// Program loader: writes a framed byte stream into instruction memory as
// 19-bit words at consecutive addresses while holding the core stalled.
module imem_loader #(
    parameter int ADDR_W  = imem_loader_pkg::ADDR_W,
    parameter int INSTR_W = imem_loader_pkg::INSTR_W,
    parameter int BYTE_W  = imem_loader_pkg::BYTE_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [ADDR_W-1:0]  n_words_m1,
    input  logic [BYTE_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               cpu_hold,
    output logic               busy,
    output logic               done,
    output logic               err
);

    import imem_loader_pkg::*;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_rem;
    logic [ADDR_W-1:0]   r_imem_addr;
    logic [INSTR_W-1:0]  r_wdata;
    logic                r_ready;
    logic                r_we;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    logic                w_xfer;
    logic                w_start;
    logic [1:0]          w_idx;
    logic [INSTR_W-1:0]  w_word_next;
    logic                w_frame_err;

    assign w_xfer  = in_valid && r_ready;
    assign w_start = (r_state == S_IDLE) && start;

    always_comb begin
        w_idx = 2'd0;
        case (r_state)
            S_B1:    w_idx = 2'd1;
            S_B2:    w_idx = 2'd2;
            default: w_idx = 2'd0;
        endcase
    end

    loader_word_asm u_asm (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_start),
        .i_load      (w_xfer),
        .i_idx       (w_idx),
        .i_byte      (in_data),
        .o_word_next (w_word_next),
        .o_frame_err (w_frame_err)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_rem       <= '0;
            r_imem_addr <= '0;
            r_wdata     <= '0;
            r_ready     <= 1'b0;
            r_we        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr  <= base_addr;
                        r_rem   <= n_words_m1;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_ready <= 1'b1;
                        r_state <= S_B0;
                    end
                end
                S_B0: begin
                    if (w_xfer) begin
                        if (w_frame_err) begin
                            r_err   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_ready <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_B1;
                        end
                    end
                end
                S_B1: begin
                    if (w_xfer) r_state <= S_B2;
                end
                S_B2: begin
                    if (w_xfer) begin
                        r_ready     <= 1'b0;
                        r_we        <= 1'b1;
                        r_imem_addr <= r_addr;
                        r_wdata     <= w_word_next;
                        r_state     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (r_rem == '0) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_addr  <= r_addr + 1'b1;
                        r_rem   <= r_rem - 1'b1;
                        r_ready <= 1'b1;
                        r_state <= S_B0;
                    end
                end
                default: begin
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = r_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = r_wdata;
    assign cpu_hold   = r_busy;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven loads with a write
// scoreboard, plus hand sequences for framing error, reset and ignored start.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] base_addr;
    logic [11:0] n_words_m1;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        imem_we;
    logic [11:0] imem_addr;
    logic [18:0] imem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;

    typedef struct {
        logic [11:0] addr;
        logic [18:0] data;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        logic [11:0]      base;
        logic [11:0]      nm1;
        int               gap;
        logic [2:0][18:0] w;
    } vec_t;

    imem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .n_words_m1 (n_words_m1),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Write monitor / scoreboard consumer.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (imem_we) begin
            chk("ready_low_in_write", 32'(in_ready), 32'd0);
            chk("done_not_with_we", 32'(done), 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", 32'(imem_addr), 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write_addr", 32'(imem_addr), 32'(e.addr));
                chk("write_data", 32'(imem_wdata), 32'(e.data));
            end
        end
    end

    task automatic put_byte(input logic [7:0] b, input int gap);
        bit ok = 1'b0;
        repeat (gap) @(negedge clk);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = b;
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end else begin
            in_valid = 1'b0;
            chk("byte_accept_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic send_word(input logic [18:0] w, input int gap);
        put_byte({5'b0, w[18:16]}, gap);
        put_byte(w[15:8], gap);
        put_byte(w[7:0], gap);
    endtask

    task automatic do_start(input logic [11:0] b, input logic [11:0] n);
        @(negedge clk);
        base_addr  = b;
        n_words_m1 = n;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("hold_after_start", 32'(cpu_hold), 32'd1);
        chk("ready_after_start", 32'(in_ready), 32'd1);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("busy_with_done", 32'(busy), 32'd0);
        chk("err_clean", 32'(err), 32'd0);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("all_writes_seen", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic push_exp(input logic [11:0] a, input logic [18:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_we"}, 32'(imem_we), 32'd0);
        chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
        chk({tag, "_wdata"}, 32'(imem_wdata), 32'd0);
        chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[3];
        int   dc;

        vecs[0] = '{base: 12'h010, nm1: 12'd0, gap: 0, w: {19'h0, 19'h0, 19'h5A37C}};
        vecs[1] = '{base: 12'h100, nm1: 12'd2, gap: 1, w: {19'h00001, 19'h7FFFF, 19'h12345}};
        vecs[2] = '{base: 12'hFFE, nm1: 12'd2, gap: 0, w: {19'h0FFFF, 19'h40A5A, 19'h3C0F0}};

        rst = 1'b0; start = 1'b0; base_addr = '0; n_words_m1 = '0;
        in_data = '0; in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k <= int'(vecs[i].nm1); k++)
                push_exp(vecs[i].base + 12'(k), vecs[i].w[k]);
            do_start(vecs[i].base, vecs[i].nm1);
            for (int k = 0; k <= int'(vecs[i].nm1); k++)
                send_word(vecs[i].w[k], vecs[i].gap);
            wait_done();
        end

        // Framing error on the second word's first byte.
        push_exp(12'h050, 19'h11111);
        dc = done_cnt;
        do_start(12'h050, 12'd1);
        send_word(19'h11111, 0);
        put_byte(8'h28, 0);
        @(negedge clk);
        chk("ferr_err", 32'(err), 32'd1);
        chk("ferr_busy", 32'(busy), 32'd0);
        chk("ferr_hold", 32'(cpu_hold), 32'd0);
        chk("ferr_ready", 32'(in_ready), 32'd0);
        repeat (6) @(negedge clk);
        chk("ferr_no_done", 32'(done_cnt - dc), 32'd0);
        chk("ferr_first_written", 32'(exp_q.size()), 32'd0);
        chk("ferr_err_sticky", 32'(err), 32'd1);
        push_exp(12'h060, 19'h6ABCD);
        do_start(12'h060, 12'd0);
        chk("ferr_cleared", 32'(err), 32'd0);
        send_word(19'h6ABCD, 0);
        wait_done();

        // Reset after two bytes of word 0.
        do_start(12'h020, 12'd0);
        put_byte(8'h01, 0);
        put_byte(8'hAB, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b1;
        push_exp(12'h030, 19'h2BEEF);
        do_start(12'h030, 12'd0);
        send_word(19'h2BEEF, 0);
        wait_done();

        // Start while busy must not disturb address or count.
        push_exp(12'h200, 19'h4CAFE);
        push_exp(12'h201, 19'h01234);
        do_start(12'h200, 12'd1);
        put_byte(8'h04, 0);
        @(negedge clk);
        base_addr  = 12'h300;
        n_words_m1 = 12'd5;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        put_byte(8'hCA, 0);
        put_byte(8'hFE, 0);
        send_word(19'h01234, 0);
        wait_done();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader for the 8-bit pipelined core. Receives a byte stream over a valid/ready handshake and assembles 19-bit instruction words from it. Writes each word into instruction memory at consecutive 12-bit addresses. Holds the core off (`cpu_hold`) while loading, so it is the writer side of the instruction memory that stage 1 reads.

## Interface
Parameters:
- `ADDR_W`, 12, instruction memory address width
- `INSTR_W`, 19, instruction word width
- `BYTE_W`, 8, stream byte width

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `start`  in  1  one-cycle request to begin a load; ignored unless idle
- `base_addr`  in  12  first write address, sampled on accepted `start`
- `n_words_m1`  in  12  number of words minus one, sampled on accepted `start`
- `in_data`  in  8  stream byte
- `in_valid`  in  1  `in_data` is valid
- `in_ready`  out  1  loader accepts a byte this cycle
- `imem_we`  out  1  instruction memory write strobe
- `imem_addr`  out  12  write address
- `imem_wdata`  out  19  write data
- `cpu_hold`  out  1  core must stay stalled/in init while high
- `busy`  out  1  load in progress
- `done`  out  1  one-cycle pulse: load completed successfully
- `err`  out  1  sticky framing error; cleared by the next accepted `start`

## Operation
- States: IDLE, B0, B1, B2, WRITE.
- IDLE:
  - On `start`: latch `base_addr` into the address register and `n_words_m1` into the remaining-count register.
  - Clear `err` and go to B0.
- A byte transfers only when `in_valid` and `in_ready` are both high. `in_ready` is 1 exactly in B0, B1 and B2.
- Byte order per word is MSB-first:
  - B0 carries `{5'b0, w[18:16]}`.
  - B1 carries `w[15:8]`.
  - B2 carries `w[7:0]`.
- B0 framing check: if `in_data[7:3]` is not zero, set `err`, discard the partial word and go to IDLE. `done` is not pulsed and no further writes occur.
- B0, B1 and B2 each advance to the next state on a transfer and hold otherwise. B2 advances to WRITE.
- WRITE, one cycle:
  - `imem_we`=1, `imem_addr`=current address, `imem_wdata`=assembled word.
  - If remaining==0, go to IDLE and pulse `done` on that transition.
  - Otherwise increment the address and decrement remaining, then go to B0.
- Address wraps modulo 4096 (0xFFF+1 → 0x000).
- `busy`=`cpu_hold`=1 in every state except IDLE.
- `start` while busy is ignored; latched parameters do not change.
- `in_valid` asserted in IDLE or WRITE is not consumed; the byte stays pending.

## Timing
- Reset values: state IDLE, `in_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_hold`=0, `busy`=0, `done`=0, `err`=0.
- Reset mid-load aborts immediately. Any partial word is dropped and no write occurs.
- `start` at edge t: `busy` and `cpu_hold` are high and `in_ready` is 1 from cycle t+1.
- Third byte accepted at edge t: `imem_we` is high during cycle t+1 only.
- Peak throughput is one word per 4 cycles (3 byte cycles + 1 WRITE).
- `done` is high in the cycle after the final WRITE, the same cycle `busy` drops. `done` and `imem_we` are never high together.
- `imem_addr` and `imem_wdata` are registered outputs. They hold their last values outside WRITE.

## Structure
- Shared package `imem_loader_pkg` holds:
  - the state enum (IDLE, B0, B1, B2, WRITE);
  - `ADDR_W`, `INSTR_W` and `BYTE_W` constants;
  - the framing mask constant (`5'b0` in the upper bits of B0).
- Sub-module `loader_word_asm`: a 19-bit shift/assemble register with load-byte-index input and clear. It owns the B0 framing check and outputs `frame_err`.
- The top level holds the FSM, address counter and remaining counter.

## Test plan
- Single word: `base_addr`=0x010, `n_words_m1`=0, bytes 0x05,0xA3,0x7C with `in_valid` held → one write of 0x5A37C at 0x010; `done` pulses 1 cycle after WRITE; `err`=0.
- Back-pressure: 3 words from 0x100, `in_valid` toggling every other cycle → writes at 0x100, 0x101 and 0x102 with correct data; no byte lost or duplicated; `in_ready`=0 during each WRITE.
- Wrap: `base_addr`=0xFFE, `n_words_m1`=2 → writes at 0xFFE, 0xFFF, 0x000.
- Framing error: second word B0 byte=0x28 → first word written, `err`=1, no second write, no `done`, `busy`=0; next `start` clears `err`.
- Reset mid-load: assert `rst` low after B1 of word 0 → all outputs at reset values, no `imem_we`; a fresh `start` loads correctly.
- `start` during busy with different `base_addr` → ignored; addresses follow the original base.
